// File: rtl/cache_pkg.sv
// cache_pkg
// Shared constants for the direct-mapped, write-through cache. The datapath
// and the controller FSM both import this package so that their widths and
// the memory wait time always agree.
//   CACHE_ADDR_W   : word-address width for CPU and main memory
//   CACHE_DATA_W   : data word width
//   CACHE_INDEX_W  : line-index bits (2**CACHE_INDEX_W lines, one word each)
//   CACHE_TAG_W    : tag bits left over after the index
//   CACHE_MEM_WAIT : main-memory latency in cycles (0..255)
//   CACHE_CTR_W    : width of the wait counter, large enough for 255
package cache_pkg;

  localparam int unsigned CACHE_ADDR_W   = 16;
  localparam int unsigned CACHE_DATA_W   = 16;
  localparam int unsigned CACHE_INDEX_W  = 4;
  localparam int unsigned CACHE_TAG_W    = CACHE_ADDR_W - CACHE_INDEX_W;
  localparam int unsigned CACHE_MEM_WAIT = 4;
  localparam int unsigned CACHE_CTR_W    = 8;

endpackage

// File: rtl/wait_counter.sv
// wait_counter
// Loadable, saturating down-counter that times main-memory accesses.
// Loading with LdCtr restarts the wait at LOAD_VAL; otherwise the count
// drops by one per cycle and parks at zero, where CtrSig is raised.
// Ports:
//   clk    : rising-edge clock
//   reset  : synchronous active-high reset (count cleared, CtrSig high)
//   LdCtr  : load LOAD_VAL into the counter
//   CtrSig : count is zero
module wait_counter
  import cache_pkg::*;
#(
  parameter int unsigned           CNT_W    = CACHE_CTR_W,
  parameter logic [CNT_W-1:0]      LOAD_VAL = CNT_W'(CACHE_MEM_WAIT)
) (
  input  logic clk,
  input  logic reset,
  input  logic LdCtr,
  output logic CtrSig
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Load wins over counting; once at zero the counter holds so the FSM can
  // sample the flag at its leisure.
  always_comb begin
    count_d = count_q;
    if (LdCtr) begin
      count_d = LOAD_VAL;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign CtrSig = (count_q == '0);

endmodule

// File: rtl/cache_datapath.sv
// cache_datapath
// Datapath of the direct-mapped, write-through cache. Latches the CPU
// request, holds the tag/valid/data arrays and steers words between CPU,
// array and main memory under the controller FSM's strobes.
// Ports:
//   clk, reset     : clock and synchronous active-high reset
//   Addr, DIn      : CPU word address and write data
//   DOut           : registered CPU read data
//   LdCtr          : latch Addr/DIn and restart the memory wait counter
//   W, WSel        : write line at latched index; source 0=din_q, 1=MDat
//   RSel, RdyEn    : capture DOut; source 0=array, 1=MDat
//   M, V           : tag match and valid bit for the latched address
//   CtrSig         : memory wait has elapsed
//   MAddr, MDOut   : memory address and write data (latched request)
//   MDat           : memory read data
module cache_datapath
  import cache_pkg::*;
#(
  parameter int unsigned ADDR_W   = CACHE_ADDR_W,
  parameter int unsigned DATA_W   = CACHE_DATA_W,
  parameter int unsigned INDEX_W  = CACHE_INDEX_W,
  parameter int unsigned MEM_WAIT = CACHE_MEM_WAIT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] DIn,
  output logic [DATA_W-1:0] DOut,
  input  logic              LdCtr,
  input  logic              W,
  input  logic              WSel,
  input  logic              RSel,
  input  logic              RdyEn,
  output logic              M,
  output logic              V,
  output logic              CtrSig,
  output logic [ADDR_W-1:0] MAddr,
  output logic [DATA_W-1:0] MDOut,
  input  logic [DATA_W-1:0] MDat
);

  localparam int unsigned TAG_W  = ADDR_W - INDEX_W;
  localparam int unsigned NLINES = 1 << INDEX_W;

  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]  din_q, din_d;
  logic [DATA_W-1:0]  dout_q, dout_d;
  logic [NLINES-1:0]  valid_q, valid_d;
  logic [TAG_W-1:0]   tag_array_q  [NLINES];
  logic [TAG_W-1:0]   tag_array_d  [NLINES];
  logic [DATA_W-1:0]  data_array_q [NLINES];
  logic [DATA_W-1:0]  data_array_d [NLINES];

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;

  assign index = addr_q[INDEX_W-1:0];
  assign tag   = addr_q[ADDR_W-1:INDEX_W];

  // Request latch. A write in the same cycle as LdCtr still sees the old
  // addr_q/din_q because the arrays below index with the pre-edge values.
  always_comb begin
    addr_d = addr_q;
    din_d  = din_q;
    if (LdCtr) begin
      addr_d = Addr;
      din_d  = DIn;
    end
  end

  // Line write: replacement simply overwrites tag and data, since a
  // write-through cache never holds dirty data that would need evicting.
  always_comb begin
    valid_d      = valid_q;
    tag_array_d  = tag_array_q;
    data_array_d = data_array_q;
    if (W) begin
      valid_d[index]      = 1'b1;
      tag_array_d[index]  = tag;
      data_array_d[index] = WSel ? MDat : din_q;
    end
  end

  // Read capture uses the pre-edge array contents, so a simultaneous write
  // is not seen here; the FSM forwards fill data with RSel=1 instead.
  always_comb begin
    dout_d = dout_q;
    if (RdyEn) begin
      dout_d = RSel ? MDat : data_array_q[index];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      valid_q <= '0;
    end else begin
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are meaningless while valid is clear, so they are
  // not reset; they are only frozen during reset so an abandoned write is lost.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_array_q  <= tag_array_d;
      data_array_q <= data_array_d;
    end
  end

  wait_counter #(
    .CNT_W    (CACHE_CTR_W),
    .LOAD_VAL (CACHE_CTR_W'(MEM_WAIT))
  ) u_wait_counter (
    .clk    (clk),
    .reset  (reset),
    .LdCtr  (LdCtr),
    .CtrSig (CtrSig)
  );

  // Match ignores valid on purpose; the FSM combines M and V itself.
  assign M     = (tag_array_q[index] == tag);
  assign V     = valid_q[index];
  assign DOut  = dout_q;
  assign MAddr = addr_q;
  assign MDOut = din_q;

endmodule

// File: tb/tb_cache_datapath.sv
// tb_cache_datapath
// Directed, table-driven bench for cache_datapath. A second instance with a
// zero memory wait shares the stimulus to show its wait flag never drops.
module tb_cache_datapath;

  typedef struct {
    logic        ld;
    logic        w;
    logic        wsel;
    logic        rsel;
    logic        rdy;
    logic [15:0] addr;
    logic [15:0] din;
    logic [15:0] mdat;
    logic        chk_m;
    logic        exp_m;
    logic        exp_v;
    logic        exp_ctr;
    logic [15:0] exp_dout;
    logic [15:0] exp_maddr;
    logic [15:0] exp_mdout;
  } vec_t;

  logic        clk;
  logic        reset;
  logic [15:0] addr_in;
  logic [15:0] din_in;
  logic [15:0] mdat_in;
  logic        ld_ctr;
  logic        w_en;
  logic        w_sel;
  logic        r_sel;
  logic        rdy_en;
  logic [15:0] dout;
  logic        m_out;
  logic        v_out;
  logic        ctr_sig;
  logic [15:0] maddr;
  logic [15:0] mdout;

  logic [15:0] dout_z;
  logic        m_z;
  logic        v_z;
  logic        ctr_z;
  logic [15:0] maddr_z;
  logic [15:0] mdout_z;

  int vectors_applied;
  int miscompares;
  vec_t vecs[$];

  cache_datapath #(.MEM_WAIT(4)) dut (
    .clk(clk), .reset(reset), .Addr(addr_in), .DIn(din_in), .DOut(dout),
    .LdCtr(ld_ctr), .W(w_en), .WSel(w_sel), .RSel(r_sel), .RdyEn(rdy_en),
    .M(m_out), .V(v_out), .CtrSig(ctr_sig), .MAddr(maddr), .MDOut(mdout),
    .MDat(mdat_in)
  );

  cache_datapath #(.MEM_WAIT(0)) dut_nowait (
    .clk(clk), .reset(reset), .Addr(addr_in), .DIn(din_in), .DOut(dout_z),
    .LdCtr(ld_ctr), .W(w_en), .WSel(w_sel), .RSel(r_sel), .RdyEn(rdy_en),
    .M(m_z), .V(v_z), .CtrSig(ctr_z), .MAddr(maddr_z), .MDOut(mdout_z),
    .MDat(mdat_in)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One named comparison; a mismatch prints a FAIL line and bumps the count.
  task automatic checkField(input string name, input int idx,
                            input logic [15:0] act, input logic [15:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s (step %0d): got 0x%h, expected 0x%h", name, idx, act, exp);
    end
  endtask

  // Drive one vector's inputs away from the edge, then let one edge pass.
  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    ld_ctr  = v.ld;
    w_en    = v.w;
    w_sel   = v.wsel;
    r_sel   = v.rsel;
    rdy_en  = v.rdy;
    addr_in = v.addr;
    din_in  = v.din;
    mdat_in = v.mdat;
    @(posedge clk);
    #1;
  endtask

  // Compare every observable output against the vector's expectations.
  task automatic checkOutput(input vec_t v, input int idx);
    vectors_applied++;
    if (v.chk_m) checkField("M", idx, {15'd0, m_out}, {15'd0, v.exp_m});
    checkField("V", idx, {15'd0, v_out}, {15'd0, v.exp_v});
    checkField("CtrSig", idx, {15'd0, ctr_sig}, {15'd0, v.exp_ctr});
    checkField("DOut", idx, dout, v.exp_dout);
    checkField("MAddr", idx, maddr, v.exp_maddr);
    checkField("MDOut", idx, mdout, v.exp_mdout);
    checkField("CtrSig_wait0", idx, {15'd0, ctr_z}, 16'd1);
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    reset   = 1'b1;
    ld_ctr  = 1'b0;
    w_en    = 1'b0;
    w_sel   = 1'b0;
    r_sel   = 1'b0;
    rdy_en  = 1'b0;
    addr_in = 16'h0000;
    din_in  = 16'h0000;
    mdat_in = 16'h0000;

    // ld w ws rs rdy  addr      din       mdat      chkM M  V  ctr dout      maddr     mdout
    vecs.push_back('{1,0,0,0,0, 16'h0013, 16'h0000, 16'h0000, 0,0, 0, 0, 16'h0000, 16'h0013, 16'h0000});
    vecs.push_back('{0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0, 0, 0, 16'h0000, 16'h0013, 16'h0000});
    vecs.push_back('{0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0, 0, 0, 16'h0000, 16'h0013, 16'h0000});
    vecs.push_back('{0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0, 0, 0, 16'h0000, 16'h0013, 16'h0000});
    vecs.push_back('{0,0,0,0,0, 16'h0000, 16'h0000, 16'h0000, 0,0, 0, 1, 16'h0000, 16'h0013, 16'h0000});
    vecs.push_back('{0,1,1,0,0, 16'h0000, 16'h0000, 16'hBEEF, 1,1, 1, 1, 16'h0000, 16'h0013, 16'h0000});
    vecs.push_back('{0,0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 1,1, 1, 1, 16'hBEEF, 16'h0013, 16'h0000});
    vecs.push_back('{1,0,0,0,0, 16'h0023, 16'h0000, 16'h0000, 1,0, 1, 0, 16'hBEEF, 16'h0023, 16'h0000});
    vecs.push_back('{1,0,0,0,0, 16'h0013, 16'h0000, 16'h0000, 1,1, 1, 0, 16'hBEEF, 16'h0013, 16'h0000});
    vecs.push_back('{1,0,0,0,0, 16'h0013, 16'h1234, 16'h0000, 1,1, 1, 0, 16'hBEEF, 16'h0013, 16'h1234});
    vecs.push_back('{0,1,0,0,0, 16'h0000, 16'h0000, 16'h0000, 1,1, 1, 0, 16'hBEEF, 16'h0013, 16'h1234});
    vecs.push_back('{0,0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 1,1, 1, 0, 16'h1234, 16'h0013, 16'h1234});
    vecs.push_back('{0,1,1,0,1, 16'h0000, 16'h0000, 16'h5555, 1,1, 1, 0, 16'h1234, 16'h0013, 16'h1234});
    vecs.push_back('{0,0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 1,1, 1, 1, 16'h5555, 16'h0013, 16'h1234});
    vecs.push_back('{0,0,0,1,1, 16'h0000, 16'h0000, 16'hA5A5, 1,1, 1, 1, 16'hA5A5, 16'h0013, 16'h1234});
    vecs.push_back('{1,0,0,0,0, 16'h0005, 16'h0077, 16'h0000, 0,0, 0, 0, 16'hA5A5, 16'h0005, 16'h0077});
    vecs.push_back('{1,1,0,0,0, 16'h0007, 16'h0099, 16'h0000, 0,0, 0, 0, 16'hA5A5, 16'h0007, 16'h0099});
    vecs.push_back('{1,0,0,0,0, 16'h0005, 16'h0000, 16'h0000, 1,1, 1, 0, 16'hA5A5, 16'h0005, 16'h0000});
    vecs.push_back('{0,0,0,0,1, 16'h0000, 16'h0000, 16'h0000, 1,1, 1, 0, 16'h0077, 16'h0005, 16'h0000});

    // Reset state after two reset edges.
    repeat (2) @(posedge clk);
    #1;
    vectors_applied++;
    checkField("reset_V", -1, {15'd0, v_out}, 16'd0);
    checkField("reset_CtrSig", -1, {15'd0, ctr_sig}, 16'd1);
    checkField("reset_DOut", -1, dout, 16'h0000);
    checkField("reset_MAddr", -1, maddr, 16'h0000);
    checkField("reset_MDOut", -1, mdout, 16'h0000);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput(vecs[i], i);
    end

    // Reset together with a write, a read and a load: everything abandoned.
    @(negedge clk);
    reset   = 1'b1;
    ld_ctr  = 1'b1;
    w_en    = 1'b1;
    w_sel   = 1'b0;
    rdy_en  = 1'b1;
    r_sel   = 1'b1;
    addr_in = 16'h0013;
    din_in  = 16'hCAFE;
    mdat_in = 16'hCAFE;
    @(posedge clk);
    #1;
    vectors_applied++;
    checkField("rstw_V", 100, {15'd0, v_out}, 16'd0);
    checkField("rstw_CtrSig", 100, {15'd0, ctr_sig}, 16'd1);
    checkField("rstw_DOut", 100, dout, 16'h0000);
    checkField("rstw_MAddr", 100, maddr, 16'h0000);
    checkField("rstw_MDOut", 100, mdout, 16'h0000);

    // Lines 5 and 3 were valid before reset; both must now read invalid.
    @(negedge clk);
    reset   = 1'b0;
    w_en    = 1'b0;
    rdy_en  = 1'b0;
    r_sel   = 1'b0;
    ld_ctr  = 1'b1;
    addr_in = 16'h0005;
    @(posedge clk);
    #1;
    vectors_applied++;
    checkField("rstw_line5_V", 101, {15'd0, v_out}, 16'd0);
    @(negedge clk);
    addr_in = 16'h0013;
    @(posedge clk);
    #1;
    vectors_applied++;
    checkField("rstw_line3_V", 102, {15'd0, v_out}, 16'd0);
    checkField("rstw_line3_MAddr", 102, maddr, 16'h0013);
    @(negedge clk);
    ld_ctr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
